// File: rtl/bus_dest_pkg.sv
// Purpose: shared encodings for the bus destination register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_dest_pkg;

    localparam int NUM_REGS = 8;
    localparam int SEL_W    = 3;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_INC  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/bus_dest_regfile_dest_decoder.sv
// Purpose: 3-to-8 one-hot write-enable decoder with a global enable.
// Latency: combinational.
// Backpressure: none; all zeros when disabled.
module dest_decoder
    import bus_dest_pkg::*;
(
    input  logic                en,
    input  logic [SEL_W-1:0]    sel,
    output logic [NUM_REGS-1:0] we
);

    // One-hot select, gated by the enable
    always_comb begin
        we = '0;
        if (en) begin
            we[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_dest_regfile.sv
// Purpose: common-bus destination; applies LOAD/INC/CLR/NOP to one of 8 registers.
// Latency: accept at E0, register update plus done/ovf at E1; one op per 2 cycles.
// Backpressure: op_ready drops for the execute cycle; optional write protect via BUS_DEST_WPROT_EN.
module bus_dest_regfile
    import bus_dest_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [W-1:0]          bus_data,
    input  logic [SEL_W-1:0]      dest_sel,
    input  logic [1:0]            op,
    input  logic                  op_valid,
    output logic                  op_ready,
    output logic                  done,
    output logic                  ovf,
`ifdef BUS_DEST_WPROT_EN
    input  logic [NUM_REGS-1:0]   wprot_mask,
    output logic                  err,
`endif
    output logic [NUM_REGS*W-1:0] reg_q
);

    state_e                     state;
    logic [W-1:0]               hold_data;
    logic [SEL_W-1:0]           hold_sel;
    op_e                        hold_op;
    logic                       hold_prot;
    logic [NUM_REGS-1:0][W-1:0] regs;
    logic [NUM_REGS-1:0]        we;
    logic [W-1:0]               cur_q;
    logic [W-1:0]               wr_data;
    logic                       wr_en;
    logic                       ovf_now;

`ifndef BUS_DEST_WPROT_EN
    // Without protection every register is writable.
    assign hold_prot = 1'b0;
`endif

    assign cur_q   = regs[hold_sel];
    assign wr_en   = (state == ST_EXEC) && (hold_op != OP_NOP) && !hold_prot;
    assign ovf_now = (hold_op == OP_INC) && !hold_prot && (&cur_q);
    assign reg_q   = regs;

    dest_decoder u_dec (
        .en  (wr_en),
        .sel (hold_sel),
        .we  (we)
    );

    // New value for the targeted register, chosen by the held op
    always_comb begin
        wr_data = '0;
        case (hold_op)
            OP_LOAD: wr_data = hold_data;
            OP_INC:  wr_data = cur_q + {{(W-1){1'b0}}, 1'b1};
            default: wr_data = '0;
        endcase
    end

    // Handshake FSM: capture request in IDLE, execute and pulse done in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_ready  <= 1'b1;
            done      <= 1'b0;
            ovf       <= 1'b0;
            hold_data <= '0;
            hold_sel  <= '0;
            hold_op   <= OP_NOP;
`ifdef BUS_DEST_WPROT_EN
            hold_prot <= 1'b0;
            err       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            ovf  <= 1'b0;
`ifdef BUS_DEST_WPROT_EN
            err  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (op_valid && op_ready) begin
                        hold_data <= bus_data;
                        hold_sel  <= dest_sel;
                        hold_op   <= op_e'(op);
`ifdef BUS_DEST_WPROT_EN
                        hold_prot <= wprot_mask[dest_sel];
`endif
                        op_ready  <= 1'b0;
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    done     <= 1'b1;
                    ovf      <= ovf_now;
`ifdef BUS_DEST_WPROT_EN
                    err      <= hold_prot && (hold_op != OP_NOP);
`endif
                    op_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    op_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Register file: only the decoded register takes the new value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

endmodule
